// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over open-drain clock/data enables.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled transfer.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] RTS_LAST = 20'(RTS_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_prev_q;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        ack_ok_q, ack_ok_d;
  logic [19:0] cnt_q, cnt_d;
  logic        clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        clk_s, dat_s, fe_s, wd_hit_s, wd_expire_s;
  logic [19:0] wd_next_s;

  assign clk_s = clk_sync_q[1];
  assign dat_s = data_sync_q[1];
  assign fe_s  = clk_prev_q & ~clk_s;

  // Watchdog saturates at its limit so it never wraps while a transfer is stalled.
  assign wd_hit_s  = (cnt_q == TO_LAST);
  assign wd_next_s = fe_s ? 20'd0 : (wd_hit_s ? cnt_q : cnt_q + 20'd1);

`ifdef PS2_TX_TIMEOUT_EN
  assign wd_expire_s = wd_hit_s && !fe_s &&
                       ((state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE));
`else
  assign wd_expire_s = 1'b0;
`endif

  // Pad synchronisers; idle lines are high so they reset to 1 to avoid a false edge.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= 8'd0;
      parity_q  <= 1'b0;
      bit_cnt_q <= 4'd0;
      ack_ok_q  <= 1'b0;
      cnt_q     <= 20'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      ack_ok_q  <= ack_ok_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    ack_ok_d  = ack_ok_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d   = INHIBIT;
          data_d    = tx_data;
          parity_d  = odd_parity(tx_data);
          bit_cnt_d = 4'd0;
          cnt_d     = 20'd0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = RTS;
          cnt_d     = 20'd0;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      RTS: begin
        if (cnt_q == RTS_LAST) begin
          state_d  = SEND;
          cnt_d    = 20'd0;
          clk_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      SEND: begin
        cnt_d = wd_next_s;
        if (fe_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          case (bit_cnt_q)
            4'd8:    data_oe_d = ~parity_q;
            4'd9: begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end
            default: data_oe_d = ~data_q[bit_cnt_q[2:0]];
          endcase
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      ACK: begin
        cnt_d = wd_next_s;
        if (fe_s) begin
          ack_ok_d = ~dat_s;
          state_d  = WAIT_IDLE;
        end else begin
          ack_ok_d = ack_ok_q;
        end
      end
      WAIT_IDLE: begin
        cnt_d = wd_next_s;
        if (clk_s && dat_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = ack_ok_q;
          error_d = ~ack_ok_q;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
    if (wd_expire_s) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b1;
    end else begin
      error_d = error_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain pad model, PS/2 device model and timing reference.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 300;
  localparam int RTS = 40;
  localparam int TO  = 3000;
  localparam int NEVER = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
  logic       pad_clk, pad_data;

  assign pad_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign pad_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .master_clk(clk), .reset(rst), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk_in(pad_clk), .ps2_data_in(pad_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error));

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  // Reference model of one transfer, expressed as timestamps.
  bit m_busy = 1'b0;
  bit m_ack = 1'b0;
  bit m_no_dev = 1'b0;
  int m_t0 = 0;
  int m_tc = NEVER;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ($countones(b) % 2 == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    bit eb, ed, ee, eco, edo, chk_d;
    int ph;
    eb  = m_busy && (cyc >= m_t0) && (cyc < m_tc);
    ed  = m_busy && (cyc == m_tc) && m_ack;
    ee  = m_busy && (cyc == m_tc) && !m_ack;
    ph  = cyc - m_t0;
    eco = 1'b0; edo = 1'b0; chk_d = 1'b1;
    if (eb) begin
      if (ph < INH) eco = 1'b1;
      else if (ph < INH + RTS) begin eco = 1'b1; edo = 1'b1; end
      else if (m_no_dev) edo = 1'b1;
      else chk_d = 1'b0;
    end
    chk("busy", tx_busy, eb);
    chk("done", tx_done, ed);
    chk("error", tx_error, ee);
    chk("clk_oe", ps2_clk_oe, eco);
    if (chk_d) chk("data_oe", ps2_data_oe, edo);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic start_tx(input logic [7:0] b, input bit ack);
    tick(1);
    tx_start = 1'b1; tx_data = b;
    m_t0 = cyc + 1; m_tc = NEVER; m_ack = ack; m_busy = 1'b1;
    tick(1);
    tx_start = 1'b0; tx_data = 8'($urandom);
  endtask

  // Device: waits for the clock release, then clocks nfe falling edges, sampling on rising edges.
  task automatic dev_run(input int nfe, input bit ack, output logic [10:0] bits);
    int half, t_last;
    bit ok;
    half = $urandom_range(250, 100);
    bits = 11'd0;
    ok = 1'b0;
    for (int i = 0; i < INH + RTS + 20 && !ok; i++) begin
      tick(1);
      ok = (cyc > m_t0) && !ps2_clk_oe && pad_clk;
    end
    chk("clk_release", ok, 1'b1);
    tick(5);
    bits[0] = pad_data;
    for (int k = 1; k <= nfe; k++) begin
      tick(half);
      if (k == 11) begin
        dev_data_low = ack;
        tick(half / 2);
      end
      dev_clk_low = 1'b1;
      tick(half);
      if (k <= 10) bits[k] = pad_data;
      dev_clk_low = 1'b0;
      if (k == 11) begin
        t_last = cyc;
        if (ack) begin
          tick(20);
          dev_data_low = 1'b0;
          t_last = cyc;
        end
        m_tc = t_last + 3;
      end
    end
  endtask

  task automatic wait_end(input int lim);
    int n;
    n = 0;
    while (cyc <= m_tc && n < lim) begin tick(1); n++; end
    chk("end_reached", (cyc > m_tc), 1'b1);
    m_busy = 1'b0; m_no_dev = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    logic [7:0]  b;
    bit          a;
    tick(5);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_clk_oe", ps2_clk_oe, 1'b0);
    rst = 1'b0;
    tick(5);

    start_tx(8'hED, 1'b1);
    dev_run(11, 1'b1, bits);
    wait_end(50);
    chk("frame_ED", bits, 11'b111_1101_1010);

    start_tx(8'h00, 1'b0);
    dev_run(11, 1'b0, bits);
    wait_end(50);
    chk("parity_00", bits[9], 1'b1);
    chk("frame_00", bits, 11'b110_0000_0000);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      a = 1'($urandom);
      start_tx(b, a);
      dev_run(11, a, bits);
      wait_end(50);
      chk("frame_rand", bits, frame(b));
    end

    start_tx(8'hFF, 1'b1);
    tick(100);
    tx_start = 1'b1; tx_data = 8'h55;
    tick(1);
    tx_start = 1'b0;
    dev_run(11, 1'b1, bits);
    wait_end(50);
    chk("frame_lockout", bits, frame(8'hFF));

`ifdef PS2_TX_TIMEOUT_EN
    start_tx(8'hA5, 1'b0);
    m_no_dev = 1'b1;
    m_tc = m_t0 + INH + RTS + TO;
    wait_end(INH + RTS + TO + 50);
`else
    start_tx(8'hA5, 1'b0);
    m_no_dev = 1'b1;
    tick(INH + RTS + 5000);
    chk("stall_busy", tx_busy, 1'b1);
    rst = 1'b1;
    m_busy = 1'b0; m_no_dev = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
`endif

    start_tx(8'h3C, 1'b1);
    dev_run(5, 1'b1, bits);
    rst = 1'b1;
    m_busy = 1'b0;
    #1;
    chk("rst_async_busy", tx_busy, 1'b0);
    chk("rst_async_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_async_data_oe", ps2_data_oe, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(3);
    start_tx(8'hF4, 1'b1);
    dev_run(11, 1'b1, bits);
    wait_end(50);
    chk("frame_F4", bits, frame(8'hF4));

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
